// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide stage.
//   md_state_t   : FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//   MD_ITER      : number of RUN iterations (one result bit per clock)
//   RSTATUS_*    : status codes reported on an exception
//   md_abs       : two's-complement magnitude of a 32-bit value
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  localparam int          MD_ITER      = 32;
  localparam logic [31:0] RSTATUS_MULT = 32'd4;
  localparam logic [31:0] RSTATUS_DIV  = 32'd5;

  // Magnitude as an unsigned 32-bit value; -2^31 maps to 0x80000000 (= 2^31).
  function automatic logic [31:0] md_abs(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/dflipflop.sv
// Single-bit D flip-flop with enable and asynchronous active-high clear.
//   clock, reset : clock / async clear
//   en_i, d_i    : load enable and data
//   q_o          : stored bit
module dflipflop (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     q_o <= 1'b0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/multdiv_counter.sv
// 6-bit iteration counter: synchronous clear has priority over enable.
//   clock, reset : clock / async clear
//   clr_i        : synchronous clear to zero
//   en_i         : increment enable
//   count_o      : current count
module multdiv_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [5:0] count_o
);

  logic [5:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      count_q <= '0;
    else if (clr_i) count_q <= '0;
    else if (en_i)  count_q <= count_q + 6'd1;
  end

  assign count_o = count_q;

endmodule

// File: rtl/register.sv
// 32-bit register built from dflipflop cells, with enable and async clear.
//   clock, reset : clock / async clear
//   en_i, d_i    : load enable and data word
//   q_o          : stored word
module register (
  input  logic        clock,
  input  logic        reset,
  input  logic        en_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  for (genvar i = 0; i < 32; i++) begin : g_bit
    dflipflop u_dff (
      .clock (clock),
      .reset (reset),
      .en_i  (en_i),
      .d_i   (d_i[i]),
      .q_o   (q_o[i])
    );
  end

endmodule

// File: rtl/multdiv_stage.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes) unit for the execute stage. One start pulse launches a
// 32-iteration operation; the result is loaded on entry to DONE and
// data_resultRDY pulses on the following edge (33 edges after start).
//   clock, reset              : clock / async active-high reset
//   ctrl_MULT, ctrl_DIV       : start pulses (multiply wins if both)
//   data_operandA/B           : operands, sampled on the start edge only
//   data_result               : registered result
//   data_exception            : overflow / divide-by-zero of last op
//   data_resultRDY            : one-cycle result-valid pulse
//   busy                      : stall request while not IDLE
//   isRStatus_out, rStatus_out: exception flag and status code
module multdiv_stage
  import multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic        isRStatus_out,
  output logic [31:0] rStatus_out
);

  md_state_t state_q, state_d;

  logic [5:0] cnt;
  logic       start, last_iter;
  logic       cnt_clr, cnt_en, load_ops, do_iter, done_load;

  // Working registers. For multiply: acc/q/q1 form the Booth product register
  // and opd holds the multiplicand. For divide: acc is the partial remainder,
  // q shifts the dividend magnitude out and the quotient in, opd is |divisor|.
  logic               op_mult_q;
  logic signed [32:0] acc_q, acc_d;
  logic [31:0]        q_q, q_d;
  logic               q1_q, q1_d;
  logic [31:0]        opd_q;
  logic               neg_q, dz_q;

  logic signed [32:0] mcand_ext, booth_sum, rem_sh, trial;
  logic [63:0]        prod;
  logic [31:0]        res_d, rstat_d;
  logic               exc_d;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last_iter = (cnt == 6'(MD_ITER - 1));

  multdiv_counter u_cnt (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start pulses are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    busy      = 1'b0;
    load_ops  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    do_iter   = 1'b0;
    done_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ops = start;
        cnt_clr  = start;
      end
      ST_RUN: begin
        busy      = 1'b1;
        cnt_en    = 1'b1;
        do_iter   = 1'b1;
        done_load = last_iter;
      end
      ST_DONE: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  function automatic logic mul_ovf(input logic [63:0] p);
    // Product fits in 32 signed bits only if bits 63..31 are a pure sign run.
    return !((&p[63:31]) || !(|p[63:31]));
  endfunction

  function automatic logic [31:0] div_apply_sign(input logic [31:0] mag, input logic neg);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  // One iteration step of the active operation
  always_comb begin
    mcand_ext = $signed({opd_q[31], opd_q});
    booth_sum = acc_q;
    rem_sh    = $signed({acc_q[31:0], q_q[31]});
    trial     = rem_sh - $signed({1'b0, opd_q});
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    if (op_mult_q) begin
      case ({q_q[0], q1_q})
        2'b01:   booth_sum = acc_q + mcand_ext;
        2'b10:   booth_sum = acc_q - mcand_ext;
        default: booth_sum = acc_q;
      endcase
      acc_d = booth_sum >>> 1;
      q_d   = {booth_sum[0], q_q[31:1]};
      q1_d  = q_q[0];
    end else if (!trial[32]) begin
      acc_d = trial;
      q_d   = {q_q[30:0], 1'b1};
    end else begin
      acc_d = rem_sh;
      q_d   = {q_q[30:0], 1'b0};
    end
  end

  // Final result from the post-iteration values, so it is ready to load on
  // the same edge that enters DONE.
  always_comb begin
    prod = {acc_d[31:0], q_d};
    if (op_mult_q) begin
      res_d = prod[31:0];
      exc_d = mul_ovf(prod);
    end else if (dz_q) begin
      res_d = '0;
      exc_d = 1'b1;
    end else begin
      res_d = div_apply_sign(q_d, neg_q);
      // A positive quotient of 2^31 (only 0x80000000 / -1) cannot be represented.
      exc_d = !neg_q && q_d[31];
    end
    rstat_d = exc_d ? (op_mult_q ? RSTATUS_MULT : RSTATUS_DIV) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_mult_q <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      opd_q     <= '0;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else if (load_ops) begin
      op_mult_q <= ctrl_MULT;
      acc_q     <= '0;
      q1_q      <= 1'b0;
      if (ctrl_MULT) begin
        opd_q <= data_operandA;
        q_q   <= data_operandB;
        neg_q <= 1'b0;
        dz_q  <= 1'b0;
      end else begin
        opd_q <= md_abs(data_operandB);
        q_q   <= md_abs(data_operandA);
        neg_q <= data_operandA[31] ^ data_operandB[31];
        dz_q  <= (data_operandB == '0);
      end
    end else if (do_iter) begin
      acc_q <= acc_d;
      q_q   <= q_d;
      q1_q  <= q1_d;
    end
  end

  // Output holding registers
  register u_res (
    .clock (clock),
    .reset (reset),
    .en_i  (done_load),
    .d_i   (res_d),
    .q_o   (data_result)
  );

  register u_rstat (
    .clock (clock),
    .reset (reset),
    .en_i  (done_load),
    .d_i   (rstat_d),
    .q_o   (rStatus_out)
  );

  dflipflop u_exc (
    .clock (clock),
    .reset (reset),
    .en_i  (done_load),
    .d_i   (exc_d),
    .q_o   (data_exception)
  );

  // The ready pulse is the registered DONE state, landing one edge after the
  // result registers load.
  dflipflop u_rdy (
    .clock (clock),
    .reset (reset),
    .en_i  (1'b1),
    .d_i   (state_q == ST_DONE),
    .q_o   (data_resultRDY)
  );

  assign isRStatus_out = data_exception;

endmodule

// File: tb/tb_multdiv_stage.sv
module tb_multdiv_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic        isRStatus_out;
  logic [31:0] rStatus_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rst;
  } exp_t;

  exp_t sb[$];

  multdiv_stage dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .isRStatus_out  (isRStatus_out),
    .rStatus_out    (rStatus_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: native 64-bit multiply and truncating integer divide.
  function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      p;
    logic [63:0] pv;
    int          qa, qb, qq;
    if (m) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      pv    = p;
      e.res = pv[31:0];
      e.exc = !((pv[63:31] == 33'h0) || (pv[63:31] == 33'h1_FFFF_FFFF));
    end else if (b == 32'h0) begin
      e.res = 32'h0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      qa    = $signed(a);
      qb    = $signed(b);
      qq    = qa / qb;
      e.res = qq;
      e.exc = 1'b0;
    end
    e.rst = e.exc ? (m ? 32'd4 : 32'd5) : 32'd0;
    return e;
  endfunction

  // Called at posedge+#1; drives a start pulse for one edge, then scrambles
  // the operand inputs so that only start-edge sampling gives the right answer.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    sb.push_back(model(m, a, b));
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = ~a;
    data_operandB = b ^ 32'h5A5A_0F0F;
  endtask

  // Waits for the ready pulse (bounded), checks latency, busy duration and
  // the scoreboard entry. Optionally injects a DIV pulse at cycle inj_at.
  task automatic wait_rdy(input string name, input int inj_at,
                          input logic [31:0] inj_a, input logic [31:0] inj_b);
    int   busy_n;
    bit   seen;
    exp_t e;
    busy_n = busy ? 1 : 0;
    seen   = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      if (k == inj_at) begin
        ctrl_DIV      = 1'b1;
        data_operandA = inj_a;
        data_operandB = inj_b;
      end
      if (busy) busy_n++;
      if (data_resultRDY) begin
        seen = 1'b1;
        chk({name, " latency"}, 32'(k), 32'd33);
        chk({name, " busy_cycles"}, 32'(busy_n), 32'd33);
        chk({name, " pending"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({name, " result"}, data_result, e.res);
          chk({name, " exception"}, {31'b0, data_exception}, {31'b0, e.exc});
          chk({name, " isRStatus"}, {31'b0, isRStatus_out}, {31'b0, e.exc});
          chk({name, " rStatus"}, rStatus_out, e.rst);
        end
      end
    end
    if (!seen) chk({name, " rdy_timeout"}, {31'b0, data_resultRDY}, 32'd1);
    else begin
      @(posedge clock); #1;
      chk({name, " rdy_one_cycle"}, {31'b0, data_resultRDY}, 32'd0);
    end
  endtask

  task automatic quiet(input string name, input int n);
    int c;
    c = 0;
    repeat (n) begin
      @(posedge clock); #1;
      if (data_resultRDY) c++;
    end
    chk(name, 32'(c), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " result"}, data_result, 32'd0);
    chk({name, " exception"}, {31'b0, data_exception}, 32'd0);
    chk({name, " rdy"}, {31'b0, data_resultRDY}, 32'd0);
    chk({name, " busy"}, {31'b0, busy}, 32'd0);
    chk({name, " isRStatus"}, {31'b0, isRStatus_out}, 32'd0);
    chk({name, " rStatus"}, rStatus_out, 32'd0);
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Basic multiply
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_rdy("mul_7x-3", 0, '0, '0);
    start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2);
    wait_rdy("mul_ovf", 0, '0, '0);
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_rdy("mul_min_min", 0, '0, '0);
    start_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
    wait_rdy("mul_neg_neg", 0, '0, '0);
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'hFFFF_8000);
    wait_rdy("mul_edge_min", 0, '0, '0);

    // Divide
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_rdy("div_100/7", 0, '0, '0);
    start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_rdy("div_-100/7", 0, '0, '0);
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    wait_rdy("div_by_zero", 0, '0, '0);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy("div_min/-1", 0, '0, '0);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'd1);
    wait_rdy("div_min/1", 0, '0, '0);
    start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_rdy("div_7/-2", 0, '0, '0);
    start_op(1'b0, 1'b1, 32'd0, 32'd5);
    wait_rdy("div_0/5", 0, '0, '0);

    // Start ignored while running
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    wait_rdy("mul_3x4_inj", 10, 32'd9, 32'd3);
    quiet("no_second_rdy", 40);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Both start lines together: multiply wins
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    wait_rdy("both_start", 0, '0, '0);

    // Leave non-zero outputs behind, then abort a divide with reset
    start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2);
    wait_rdy("mul_ovf_pre", 0, '0, '0);
    start_op(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (9) @(posedge clock);
    #1;
    chk("abort busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("abort");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    void'(sb.pop_front());
    quiet("abort no_rdy", 40);

    // First edge after reset release accepts a start
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_rdy("post_reset_div", 0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
